// File: rtl/ds_capture_buffer_if.sv
// Bus bundle for the decimated-sample capture buffer: filter-chain strobe,
// CPU control pulses, CPU read port and status outputs.
interface ds_capture_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic [DW-1:0] sample_in;
    logic          sample_ce;
    logic          arm;
    logic          abort;
    logic [AW:0]   capture_len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          done_stb;
    logic [AW:0]   count;
    logic [DW-1:0] peak_abs;

    modport master (
        output sample_in, sample_ce, arm, abort, capture_len, rd_addr,
        input  rd_data, busy, done, done_stb, count, peak_abs
    );

    modport slave (
        input  sample_in, sample_ce, arm, abort, capture_len, rd_addr,
        output rd_data, busy, done, done_stb, count, peak_abs
    );
endinterface

// File: rtl/ds_capture_buffer.sv
// Captures a CPU-requested run of decimated samples into RAM, tracking the
// saturated peak magnitude, with a read-first synchronous CPU read port.
module ds_capture_buffer #(
    parameter int DW    = 16,
    parameter int AW    = 10,
    parameter int DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    ds_capture_buffer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
        if (x == {1'b1, {(DW-1){1'b0}}}) begin
            return {1'b0, {(DW-1){1'b1}}};
        end else if (x[DW-1]) begin
            return ~x + DW'(1);
        end else begin
            return x;
        end
    endfunction

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic          done_stb_q;
    logic [AW:0]   count_q;
    logic [AW:0]   len_q;
    logic [AW-1:0] wr_ptr_q;
    logic [DW-1:0] peak_q;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic [AW:0]   count_d;
    logic [AW:0]   len_d;
    logic [DW-1:0] abs_d;
    logic          wr_en_d;

    assign count_d = count_q + (AW+1)'(1);
    assign abs_d   = abs_sat(bus.sample_in);
    assign len_d   = ((bus.capture_len == '0) || (bus.capture_len > DEPTH_L)) ? DEPTH_L
                                                                              : bus.capture_len;
    // Abort and reset both suppress a write arriving in their cycle
    assign wr_en_d = (state_q == ST_CAPTURE) && bus.sample_ce && !bus.abort && !reset;

    // Capture control FSM and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_stb_q <= 1'b0;
            count_q    <= '0;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            peak_q     <= '0;
        end else if (bus.abort) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_stb_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_stb_q <= 1'b0;
                    if (bus.arm) begin
                        state_q  <= ST_CAPTURE;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        len_q    <= len_d;
                        count_q  <= '0;
                        wr_ptr_q <= '0;
                        peak_q   <= '0;
                    end
                end
                ST_CAPTURE: begin
                    done_stb_q <= 1'b0;
                    if (bus.sample_ce) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        count_q  <= count_d;
                        if (abs_d > peak_q) begin
                            peak_q <= abs_d;
                        end
                        if (count_d == len_q) begin
                            state_q    <= ST_DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            done_stb_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    done_stb_q <= 1'b0;
                end
            endcase
        end
    end

    // Sample RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[wr_ptr_q] <= bus.sample_in;
        end
    end

    // CPU read port, read-first against a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[bus.rd_addr];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.done_stb = done_stb_q;
    assign bus.count    = count_q;
    assign bus.peak_abs = peak_q;
endmodule

// File: doc/ds_capture_buffer.md
Name: ds_capture_buffer

Overview:
Capture stage directly downstream of the decimating filter chain (CIC -> compensator -> half-band). Consumes the 16-bit decimated output and its one-cycle strobe, and writes a software-requested number of consecutive samples into an on-chip RAM. Tracks the peak absolute value over the capture window. The CPU reads results back through a synchronous read port, so decimated data reaches the SoC bus without per-sample CPU servicing.

Parameters:
DW, 16, sample width (matches the filter chain output)
AW, 10, RAM address width
DEPTH, 1024, RAM depth; must equal 2**AW

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sample_in  in  DW  signed decimated sample; valid only when sample_ce=1
sample_ce  in  1  one-cycle sample strobe from the filter chain's ce_out
arm  in  1  one-cycle start pulse; latches capture_len
abort  in  1  one-cycle pulse; stops the capture and returns to IDLE
capture_len  in  AW+1  number of samples to capture; sampled only on arm
rd_addr  in  AW  CPU read address
rd_data  out  DW  mem[rd_addr], registered, 1-cycle latency
busy  out  1  high while in CAPTURE
done  out  1  level; high in DONE until the next arm or abort
done_stb  out  1  one-cycle pulse on entry to DONE (IRQ source)
count  out  AW+1  number of samples written in the current/last capture
peak_abs  out  DW  max |sample| over the current/last capture, unsigned

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, done_stb=0, count=0, peak_abs=0, rd_data=0, internal len_q=0, wr_ptr=0. RAM contents are not cleared.
- The block has three states: IDLE, CAPTURE, DONE.
- IDLE / DONE, arm=1:
  - Go to CAPTURE next cycle.
  - Latch len_q from capture_len: 0 -> DEPTH, values >DEPTH clamp to DEPTH.
  - Clear count, wr_ptr, and peak_abs.
  - Clear done.
  - A sample_ce in the same cycle as arm is NOT captured.
- CAPTURE, sample_ce=1:
  - mem[wr_ptr] <= sample_in; wr_ptr++, count++.
  - peak_abs <= max(peak_abs, |sample_in|).
- CAPTURE end: if the write makes count equal len_q, the next cycle has state=DONE, busy=0, done=1, and done_stb=1 for exactly that cycle.
- CAPTURE, arm=1: ignored; no relatch, no restart.
- Abort in any state: next cycle has state=IDLE, busy=0, done=0. count and peak_abs hold their partial values. A sample_ce in the abort cycle is NOT written.
- Abort wins over arm when both arrive in the same cycle.
- Abs rule: |x| for x>=0 is x; for x<0 it is -x. The most negative code (-2**(DW-1)) saturates to 2**(DW-1)-1. The result is treated as unsigned for comparison.
- wr_ptr never wraps within a capture, since len_q<=DEPTH. It is cleared on arm.
- Read port: rd_data <= mem[rd_addr] on every clk, independent of state.
  - Reading during CAPTURE is legal. Locations not yet written return stale data.
  - A same-cycle write and read of the same address returns the old data (read-first).
- sample_ce is assumed at most one cycle wide; back-to-back strobes on consecutive cycles must each be captured.
- Reset mid-capture: on the next cycle all registers return to their reset values; RAM is untouched.
- Output latency:
  - count, peak_abs, and busy update one cycle after the triggering input.
  - done and done_stb update one cycle after the final write.

Test Plan:
- Basic capture:
  - Stimulus: arm with capture_len=8; sample_ce every 4 cycles with samples 1..8.
  - Required: busy=1 from the cycle after arm; count=8; done_stb pulses once, one cycle after the 8th strobe.
  - Readback: rd_addr 0..7 returns 1..8, each one cycle after the address is applied.
- Peak and saturation:
  - Stimulus: capture_len=4 with samples {100, -32768, 5, -200}.
  - Required: peak_abs=32767; with {3, -7, 2, 6} instead, peak_abs=7.
- Length edge cases:
  - Stimulus: capture_len=0, then capture_len=2000 with AW=10.
  - Required: both captures take exactly 1024 samples; the 1025th strobe is not written and count=1024.
- Simultaneous events:
  - arm and sample_ce in the same cycle: that sample is absent from mem[0].
  - arm during CAPTURE at count=3 of 8: capture continues to 8 without restart.
  - abort and arm together in DONE: state=IDLE, done=0.
- Abort and reset mid-capture:
  - Abort at count=5 of 16: busy=0, done=0, count stays 5, no done_stb.
  - Reset during CAPTURE: all outputs return to 0 next cycle, and a fresh arm captures normally.
- Back-to-back strobes:
  - Stimulus: sample_ce high for 6 consecutive cycles with capture_len=6.
  - Required: all 6 samples stored in order; done=1 on cycle 7.
